mem_wb_pipe: RTL

Parametrised MEM/WB pipeline stage register, the successor of the fixed-width MEM/WB latch. It sits between the memory-access stage and register-file write-back, carrying the write address, write enable and write data. It adds a valid/ready handshake with a two-entry skid buffer so that a write-back stall does not combinationally ripple into MEM. It also adds a synchronous flush and an optional HI/LO write channel.

---
 rtl/mem_wb_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe
// Purpose  : MEM/WB stage register with valid/ready handshake, two-entry skid
//            buffer and synchronous flush. Optional HI/LO write channel is
//            enabled by defining MEMWB_HILO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
`ifdef MEMWB_HILO_EN
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
`ifdef MEMWB_HILO_EN
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
`endif
  output logic [1:0]        occupancy
);

  localparam int GPR_W = ADDR_W + 1 + DATA_W;
`ifdef MEMWB_HILO_EN
  localparam int ENT_W = GPR_W + 1 + 2 * DATA_W;
`else
  localparam int ENT_W = GPR_W;
`endif

  // Occupancy doubles as the state encoding: main valid = !EMPTY, skid valid = FULL.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ENT_W-1:0]   r_main;
  logic [ENT_W-1:0]   r_skid;
  logic [ENT_W-1:0]   w_in;
  logic               w_push;
  logic               w_pop;
  logic               w_ld_main_in;
  logic               w_ld_main_skid;
  logic               w_ld_skid;

`ifdef MEMWB_HILO_EN
  assign w_in = {mem_whilo, mem_hi, mem_lo, mem_wd, mem_wreg, mem_wdata};
`else
  assign w_in = {mem_wd, mem_wreg, mem_wdata};
`endif

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign occupancy = r_state;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_push) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Flush leaves data untouched so wb_* keep showing the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= w_in;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in;
      end
    end
  end

  assign wb_wdata = r_main[DATA_W-1:0];
  assign wb_wreg  = r_main[DATA_W] & out_valid;
  assign wb_wd    = r_main[DATA_W+1 +: ADDR_W];
`ifdef MEMWB_HILO_EN
  assign wb_lo    = r_main[GPR_W +: DATA_W];
  assign wb_hi    = r_main[GPR_W+DATA_W +: DATA_W];
  assign wb_whilo = r_main[GPR_W+2*DATA_W] & out_valid;
`endif

endmodule
`default_nettype wire
